map_scroll_ctrl: RTL and testbench
==================================

Name: map_scroll_ctrl

Overview:
Per-frame scroll sequencer for the tiled map renderer. Generates the 8-bit horizontal map offset consumed by the map drawing stage and steps it only at the start of vertical blanking, so one frame never shows two offsets. Runs a start/ramp/cruise/pause/done state machine with speed ramping, and reports the per-frame step so sprite logic can move in lockstep with the map.

Parameters:
SPEED_MAX, 4, cruise speed in offset units per frame (1..7)
ACCEL_FRAMES, 30, frames spent at each speed during ramp-up (1..255)
OFFSET_MAX, 255, last legal offset value (1..255)
WRAP, 1, 1 = offset wraps modulo OFFSET_MAX+1; 0 = stop at OFFSET_MAX and enter DONE

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
vblnk  in  1  vertical blank from VGA timing chain
start  in  1  level; leaves IDLE
pause  in  1  level; holds scrolling while high
restart  in  1  1-cycle pulse; return to IDLE with offset 0
map_ofset  out  8  offset to map renderer, registered
step_valid  out  1  1-cycle pulse on each frame-tick where offset changed
step  out  3  amount added on that tick (valid with step_valid)
state  out  3  IDLE=0, RAMP=1, CRUISE=2, PAUSED=3, DONE=4
end_reached  out  1  high in DONE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs 0 and state IDLE; speed=0, frame counter=0, vblnk_q=0.
- frame_tick: registered vblnk_q; tick = vblnk & ~vblnk_q, one cycle per frame. map_ofset updates on the clock edge after tick, within vblank.
- Priority every cycle: restart > pause > start > tick processing.
- IDLE: offset held at its reset/restart value of 0. start=1 -> RAMP, speed=1, frame counter=0. No offset change in the transition cycle, even if tick coincides.
- RAMP: each tick sets offset += speed and increments the frame counter. When the counter reaches ACCEL_FRAMES-1, the counter clears and speed increments. The tick where speed becomes SPEED_MAX moves to CRUISE, using the old speed for that tick's add.
- CRUISE: each tick sets offset += SPEED_MAX.
- PAUSED: entered from RAMP or CRUISE when pause=1. The previous state is saved, ticks are ignored, and speed and counter are frozen. pause=0 returns to the saved state. A tick in the same cycle pause asserts does not advance.
- Advance arithmetic: sum = offset + speed in 9 bits.
  - WRAP=1: sum > OFFSET_MAX gives offset = sum - (OFFSET_MAX+1).
  - WRAP=0: sum >= OFFSET_MAX gives offset = OFFSET_MAX, step = OFFSET_MAX - old offset, state -> DONE.
- DONE: offset frozen, end_reached=1, only restart leaves. start and pause are ignored.
- restart from any state: next cycle offset=0, speed=0, counter=0, state=IDLE, no step_valid.
- step_valid: asserted exactly on the cycle map_ofset changes. A zero-length step is never flagged.
- start held high after restart re-enters RAMP on the cycle after IDLE is reached.

Test Plan:
- Reset, then start=1, run 3 frames -> state=1; offsets 1,2,3 on successive ticks; step=1 with step_valid each tick.
- ACCEL_FRAMES=2, SPEED_MAX=3, WRAP=1, start -> offsets 1,2,4,6,9,12,15; state=2 after the 4th tick.
- WRAP=1, OFFSET_MAX=255, offset 254 in CRUISE speed 4 -> next offset 2, step=4.
- WRAP=0, offset 253, speed 4 -> offset 255, step=2, state=4, end_reached=1. Further ticks produce no step_valid.
- Pause asserted in the same cycle as a tick in RAMP -> offset unchanged. Hold 5 frames; release -> resumes RAMP with the same speed and counter.
- restart mid-CRUISE with offset 100 -> next cycle map_ofset=0, state=0. With start still high, the cycle after enters RAMP.

Source files
------------

// File: rtl/map_scroll_ctrl.sv
// Per-frame horizontal scroll sequencer: ramps speed up to a cruise rate and
// steps the map offset once per frame, at the rising edge of vertical blank.
module map_scroll_ctrl #(
  parameter int SPEED_MAX    = 4,
  parameter int ACCEL_FRAMES = 30,
  parameter int OFFSET_MAX   = 255,
  parameter int WRAP         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       pause,
  input  logic       restart,
  output logic [7:0] map_ofset,
  output logic       step_valid,
  output logic [2:0] step,
  output logic [2:0] state,
  output logic       end_reached
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAMP   = 3'd1,
    S_CRUISE = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } st_t;

  st_t        st_q, st_d, saved_q, saved_d;
  logic [2:0] speed_q, speed_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ofs_d;
  logic [2:0] step_d;
  logic       sv_d;
  logic       vblnk_q;
  logic       tick;
  logic [2:0] add;
  logic [11:0] adv;
  logic [7:0] adv_ofs;
  logic [2:0] adv_step;
  logic       adv_done;

  // Returns {done, step, new_offset} for one frame's advance; in stop mode the
  // offset clamps at OFFSET_MAX and the reported step is the distance covered.
  function automatic logic [11:0] advance(input logic [7:0] ofs, input logic [2:0] amt);
    logic [8:0] sum;
    logic [7:0] nofs;
    logic [2:0] stp;
    logic       done;
    sum  = {1'b0, ofs} + {6'd0, amt};
    nofs = sum[7:0];
    stp  = amt;
    done = 1'b0;
    if (WRAP != 0) begin
      if (sum > 9'(OFFSET_MAX))
        nofs = 8'(sum - 9'(OFFSET_MAX + 1));
    end else if (sum >= 9'(OFFSET_MAX)) begin
      nofs = 8'(OFFSET_MAX);
      stp  = 3'(8'(OFFSET_MAX) - ofs);
      done = 1'b1;
    end
    return {done, stp, nofs};
  endfunction

  assign tick        = vblnk & ~vblnk_q;
  assign add         = (st_q == S_CRUISE) ? 3'(SPEED_MAX) : speed_q;
  assign adv         = advance(map_ofset, add);
  assign adv_ofs     = adv[7:0];
  assign adv_step    = adv[10:8];
  assign adv_done    = adv[11];
  assign state       = st_q;
  assign end_reached = (st_q == S_DONE);

  always_comb begin
    st_d    = st_q;
    saved_d = saved_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    ofs_d   = map_ofset;
    step_d  = step;
    sv_d    = 1'b0;
    if (restart) begin
      st_d    = S_IDLE;
      speed_d = 3'd0;
      cnt_d   = 8'd0;
      ofs_d   = 8'd0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (!pause && start) begin
            st_d    = S_RAMP;
            speed_d = 3'd1;
            cnt_d   = 8'd0;
          end
        end
        S_RAMP, S_CRUISE: begin
          if (pause) begin
            saved_d = st_q;
            st_d    = S_PAUSED;
          end else if (tick) begin
            ofs_d = adv_ofs;
            if (adv_ofs != map_ofset) begin
              sv_d   = 1'b1;
              step_d = adv_step;
            end
            if (adv_done) begin
              st_d = S_DONE;
            end else if (st_q == S_RAMP) begin
              // The add above used the pre-increment speed for this frame.
              if (cnt_q == 8'(ACCEL_FRAMES - 1)) begin
                cnt_d = 8'd0;
                if (({1'b0, speed_q} + 4'd1) >= 4'(SPEED_MAX)) begin
                  speed_d = 3'(SPEED_MAX);
                  st_d    = S_CRUISE;
                end else begin
                  speed_d = speed_q + 3'd1;
                end
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
          end
        end
        S_PAUSED: begin
          if (!pause)
            st_d = saved_q;
        end
        S_DONE: begin
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= S_IDLE;
      saved_q    <= S_IDLE;
      speed_q    <= 3'd0;
      cnt_q      <= 8'd0;
      vblnk_q    <= 1'b0;
      map_ofset  <= 8'd0;
      step       <= 3'd0;
      step_valid <= 1'b0;
    end else begin
      st_q       <= st_d;
      saved_q    <= saved_d;
      speed_q    <= speed_d;
      cnt_q      <= cnt_d;
      vblnk_q    <= vblnk;
      map_ofset  <= ofs_d;
      step       <= step_d;
      step_valid <= sv_d;
    end
  end

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// Drives three parameterisations of map_scroll_ctrl with shared stimulus and
// checks every cycle against a frame-level reference model.
module tb_map_scroll_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vblnk = 1'b0, start = 1'b0, pause = 1'b0, restart = 1'b0;

  logic [7:0] ofs_o  [3];
  logic       sv_o   [3];
  logic [2:0] step_o [3];
  logic [2:0] st_o   [3];
  logic       end_o  [3];

  int checks = 0;
  int errors = 0;
  int sv_cnt [3];
  int last_step [3];

  typedef struct {
    int mode;
    int saved;
    int speed;
    int frames;
    int ofs;
    int stp;
    int sv;
    int vq;
  } mdl_t;

  mdl_t m [3];
  int SMX [3] = '{3, 4, 4};
  int ACC [3] = '{2, 1, 1};
  int OMX [3] = '{255, 255, 255};
  int WRP [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  map_scroll_ctrl #(.SPEED_MAX(3), .ACCEL_FRAMES(2), .OFFSET_MAX(255), .WRAP(1)) u0 (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .pause(pause), .restart(restart),
    .map_ofset(ofs_o[0]), .step_valid(sv_o[0]), .step(step_o[0]), .state(st_o[0]),
    .end_reached(end_o[0]));

  map_scroll_ctrl #(.SPEED_MAX(4), .ACCEL_FRAMES(1), .OFFSET_MAX(255), .WRAP(0)) u1 (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .pause(pause), .restart(restart),
    .map_ofset(ofs_o[1]), .step_valid(sv_o[1]), .step(step_o[1]), .state(st_o[1]),
    .end_reached(end_o[1]));

  map_scroll_ctrl #(.SPEED_MAX(4), .ACCEL_FRAMES(1), .OFFSET_MAX(255), .WRAP(1)) u2 (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .pause(pause), .restart(restart),
    .map_ofset(ofs_o[2]), .step_valid(sv_o[2]), .step(step_o[2]), .state(st_o[2]),
    .end_reached(end_o[2]));

  // Frame-level behaviour: one decision per cycle from the sampled inputs.
  function automatic mdl_t mstep(mdl_t c, int smx, int acc, int omx, int wrp,
                                 logic r, logic vb, logic st, logic pa, logic rs);
    mdl_t n;
    int   amt;
    int   nofs;
    logic tk;
    n    = c;
    tk   = vb && (c.vq == 0);
    n.sv = 0;
    n.vq = vb ? 1 : 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (rs) begin
      n.mode = 0; n.ofs = 0; n.speed = 0; n.frames = 0;
    end else if (c.mode == 0) begin
      if (!pa && st) begin n.mode = 1; n.speed = 1; n.frames = 0; end
    end else if (c.mode == 1 || c.mode == 2) begin
      if (pa) begin
        n.saved = c.mode; n.mode = 3;
      end else if (tk) begin
        amt = (c.mode == 2) ? smx : c.speed;
        if (wrp != 0) begin
          nofs = (c.ofs + amt) % (omx + 1);
        end else if (c.ofs + amt >= omx) begin
          nofs = omx; amt = omx - c.ofs; n.mode = 4;
        end else begin
          nofs = c.ofs + amt;
        end
        if (nofs != c.ofs) begin n.sv = 1; n.stp = amt; end
        n.ofs = nofs;
        if (c.mode == 1 && n.mode != 4) begin
          n.frames = c.frames + 1;
          if (n.frames == acc) begin
            n.frames = 0;
            n.speed  = c.speed + 1;
            if (n.speed >= smx) begin n.speed = smx; n.mode = 2; end
          end
        end
      end
    end else if (c.mode == 3) begin
      if (!pa) n.mode = c.saved;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m[i] = mstep(m[i], SMX[i], ACC[i], OMX[i], WRP[i], rst, vblnk, start, pause, restart);
      chk($sformatf("ofs%0d", i), int'(ofs_o[i]), m[i].ofs);
      chk($sformatf("sv%0d", i), int'(sv_o[i]), m[i].sv);
      chk($sformatf("state%0d", i), int'(st_o[i]), m[i].mode);
      chk($sformatf("end%0d", i), int'(end_o[i]), (m[i].mode == 4) ? 1 : 0);
      if (sv_o[i]) begin
        sv_cnt[i]++;
        last_step[i] = int'(step_o[i]);
        chk($sformatf("step%0d", i), int'(step_o[i]), m[i].stp);
      end
    end
  endtask

  task automatic frame();
    vblnk = 1'b1;
    repeat (3) cyc();
    vblnk = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    int exp0 [7] = '{1, 2, 4, 6, 9, 12, 15};
    int exps [7] = '{1, 1, 2, 2, 3, 3, 3};
    int hold, found;
    for (int i = 0; i < 3; i++) begin
      m[i] = '{default: 0}; sv_cnt[i] = 0; last_step[i] = 0;
    end

    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ofs%0d", i), int'(ofs_o[i]), 0);
      chk($sformatf("rst_step%0d", i), int'(step_o[i]), 0);
      chk($sformatf("rst_state%0d", i), int'(st_o[i]), 0);
    end

    // Ramp profile of the fast-ramping wrap instance.
    start = 1'b1;
    cyc();
    chk("start_state", int'(st_o[0]), 1);
    chk("start_ofs", int'(ofs_o[0]), 0);
    for (int k = 0; k < 7; k++) begin
      frame();
      chk($sformatf("ramp_ofs_t%0d", k + 1), int'(ofs_o[0]), exp0[k]);
      chk($sformatf("ramp_step_t%0d", k + 1), last_step[0], exps[k]);
      if (k == 2) chk("ramp_state_t3", int'(st_o[0]), 1);
      if (k == 3) chk("cruise_state_t4", int'(st_o[0]), 2);
    end

    // Run the speed-4 instances up to offset 254, then cross the top.
    found = (ofs_o[2] == 8'd254) ? 1 : 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      frame();
      if (ofs_o[2] == 8'd254) found = 1;
    end
    chk("reach254", found, 1);
    chk("reach254_u1", int'(ofs_o[1]), 254);
    frame();
    chk("wrap_ofs", int'(ofs_o[2]), 2);
    chk("wrap_step", last_step[2], 4);
    chk("stop_ofs", int'(ofs_o[1]), 255);
    chk("stop_step", last_step[1], 1);
    chk("stop_state", int'(st_o[1]), 4);
    chk("stop_end", int'(end_o[1]), 1);
    hold = sv_cnt[1];
    pause = 1'b1;
    frame();
    pause = 1'b0;
    repeat (2) frame();
    chk("done_no_steps", sv_cnt[1], hold);
    chk("done_frozen", int'(ofs_o[1]), 255);

    // Restart with start held, then pause on a tick cycle.
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("rs_ofs", int'(ofs_o[1]), 0);
    chk("rs_state", int'(st_o[1]), 0);
    cyc();
    chk("rs_reramp", int'(st_o[1]), 1);
    repeat (2) frame();
    chk("pre_pause_ofs", int'(ofs_o[0]), 2);
    vblnk = 1'b1;
    pause = 1'b1;
    cyc();
    chk("pause_tick_ofs", int'(ofs_o[0]), 2);
    chk("pause_state", int'(st_o[0]), 3);
    repeat (2) cyc();
    vblnk = 1'b0;
    repeat (3) cyc();
    repeat (5) frame();
    chk("pause_hold_ofs", int'(ofs_o[0]), 2);
    chk("pause_hold_state", int'(st_o[0]), 3);
    pause = 1'b0;
    cyc();
    chk("resume_state", int'(st_o[0]), 1);
    frame();
    chk("resume_ofs", int'(ofs_o[0]), 4);
    frame();
    chk("resume_cruise", int'(st_o[0]), 2);
    frame();
    chk("cruise_ofs", int'(ofs_o[0]), 9);

    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("rs_cruise_ofs", int'(ofs_o[0]), 0);
    chk("rs_cruise_state", int'(st_o[0]), 0);
    chk("rs_cruise_sv", int'(sv_o[0]), 0);
    cyc();
    chk("rs_cruise_reramp", int'(st_o[0]), 1);

    // Randomised phase, checked cycle by cycle against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) vblnk = ~vblnk;
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      restart = ($urandom_range(0, 199) == 0);
      cyc();
    end
    restart = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
